rtc_calendar: RTL and testbench

RTC_CALENDAR -- requirements
Module: rtc_calendar

---
 rtl/rtc_calendar.sv | 168 ++++++++++++++++
 tb/tb_rtc_calendar.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_calendar.sv
// BCD real-time clock/calendar advanced by a tick enable. Supports validated
// external time sync, leap-second insertion and a holdover timeout on sync age.
module rtc_calendar #(
  parameter int TICKS_PER_SEC = 100,
  parameter int SYNC_PHASE    = 7,
  parameter int HOLDOVER_MIN  = 1440
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       sync,
  input  logic [7:0] sync_year,
  input  logic [7:0] sync_month,
  input  logic [7:0] sync_day,
  input  logic [7:0] sync_hour,
  input  logic [7:0] sync_minute,
  input  logic [2:0] sync_dow,
  input  logic       leap_announce,
  output logic [7:0] year,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [2:0] dow,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       synced,
  output logic       sync_err
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0] PHASE_LOAD = TW'(SYNC_PHASE);
  localparam logic [15:0]   HOLD_MAX   = 16'(HOLDOVER_MIN);

  logic [TW-1:0] tick;
  logic [15:0]   holdover;
  logic          leap_pending;

  logic          sync_valid;
  logic          last_tick;
  logic [7:0]    sec_wrap_point;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;
  logic          day_wrap;
  logic          month_wrap;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_inc = (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    digits_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Leap years in 00..99: multiples of 4 expressed directly on the BCD digits.
  function automatic logic is_leap(input logic [7:0] y);
    if (!y[4])
      is_leap = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    else
      is_leap = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
  endfunction

  function automatic logic [7:0] days_in(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: days_in = 8'h30;
      8'h02:                      days_in = is_leap(y) ? 8'h29 : 8'h28;
      default:                    days_in = 8'h31;
    endcase
  endfunction

  // With valid digits, BCD values order the same as plain binary, so range
  // checks compare the packed bytes directly.
  always_comb begin
    sync_valid = 1'b0;
    if (digits_ok(sync_year) && digits_ok(sync_month) && digits_ok(sync_day) &&
        digits_ok(sync_hour) && digits_ok(sync_minute))
      sync_valid = (sync_month >= 8'h01) && (sync_month <= 8'h12) &&
                   (sync_day >= 8'h01) &&
                   (sync_day <= days_in(sync_month, sync_year)) &&
                   (sync_hour <= 8'h23) && (sync_minute <= 8'h59) &&
                   (sync_dow != 3'd0);

    last_tick      = (tick == LAST_TICK);
    sec_wrap_point = (leap_pending && minute == 8'h59) ? 8'h60 : 8'h59;
    sec_wrap       = last_tick && (second >= sec_wrap_point);
    min_wrap       = sec_wrap && (minute == 8'h59);
    hour_wrap      = min_wrap && (hour == 8'h23);
    day_wrap       = hour_wrap && (day == days_in(month, year));
    month_wrap     = day_wrap && (month == 8'h12);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year         <= 8'h00;
      month        <= 8'h01;
      day          <= 8'h01;
      dow          <= 3'd1;
      hour         <= 8'h00;
      minute       <= 8'h00;
      second       <= 8'h00;
      tick         <= '0;
      holdover     <= 16'd0;
      leap_pending <= 1'b0;
      synced       <= 1'b0;
      sec_pulse    <= 1'b0;
      min_pulse    <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      sync_err  <= 1'b0;
      if (clk_en) begin
        if (sync && sync_valid) begin
          year         <= sync_year;
          month        <= sync_month;
          day          <= sync_day;
          hour         <= sync_hour;
          minute       <= sync_minute;
          dow          <= sync_dow;
          second       <= 8'h00;
          tick         <= PHASE_LOAD;
          holdover     <= 16'd0;
          synced       <= 1'b1;
          leap_pending <= leap_announce;
        end else begin
          sync_err <= sync;
          if (last_tick) begin
            tick      <= '0;
            sec_pulse <= 1'b1;
            second    <= sec_wrap ? 8'h00 : bcd_inc(second);
          end else begin
            tick <= tick + TW'(1);
          end

          if (sec_wrap)
            leap_pending <= 1'b0;
          else if (leap_announce)
            leap_pending <= 1'b1;

          // Carry chain: each stage only moves when every lower stage wraps.
          if (sec_wrap) begin
            minute    <= min_wrap ? 8'h00 : bcd_inc(minute);
            min_pulse <= 1'b1;
            if (holdover != HOLD_MAX) begin
              holdover <= holdover + 16'd1;
              if (holdover + 16'd1 == HOLD_MAX)
                synced <= 1'b0;
            end
          end
          if (min_wrap)
            hour <= hour_wrap ? 8'h00 : bcd_inc(hour);
          if (hour_wrap) begin
            day <= day_wrap ? 8'h01 : bcd_inc(day);
            dow <= (dow == 3'd7) ? 3'd1 : dow + 3'd1;
          end
          if (day_wrap)
            month <= month_wrap ? 8'h01 : bcd_inc(month);
          if (month_wrap)
            year <= (year == 8'h99) ? 8'h00 : bcd_inc(year);
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed self-checking bench for rtc_calendar: calendar carries, leap years,
// leap seconds, sync validation, holdover timeout and asynchronous reset.
module tb_rtc_calendar;

  localparam int TPS   = 4;
  localparam int PHASE = 1;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] sync_year = 8'h00;
  logic [7:0] sync_month = 8'h00;
  logic [7:0] sync_day = 8'h00;
  logic [7:0] sync_hour = 8'h00;
  logic [7:0] sync_minute = 8'h00;
  logic [2:0] sync_dow = 3'd0;
  logic       leap_announce = 1'b0;
  logic [7:0] year, month, day, hour, minute, second;
  logic [2:0] dow;
  logic       sec_pulse, min_pulse, synced, sync_err;

  int compared = 0;
  int mismatched = 0;
  int min_seen = 0;
  int min_mark = 0;

  rtc_calendar #(
    .TICKS_PER_SEC(TPS),
    .SYNC_PHASE(PHASE),
    .HOLDOVER_MIN(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .sync(sync),
    .sync_year(sync_year),
    .sync_month(sync_month),
    .sync_day(sync_day),
    .sync_hour(sync_hour),
    .sync_minute(sync_minute),
    .sync_dow(sync_dow),
    .leap_announce(leap_announce),
    .year(year),
    .month(month),
    .day(day),
    .hour(hour),
    .minute(minute),
    .second(second),
    .dow(dow),
    .sec_pulse(sec_pulse),
    .min_pulse(min_pulse),
    .synced(synced),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input logic [47:0] exp_time,
                           input logic [2:0] exp_dow);
    checkOutput({tag, " ymdhms"}, {16'h0, year, month, day, hour, minute, second},
                {16'h0, exp_time});
    checkOutput({tag, " dow"}, {61'h0, dow}, {61'h0, exp_dow});
  endtask

  // Each tick is one clk_en cycle followed by an idle cycle; outputs are
  // sampled on the falling edge right after the enabled rising edge.
  task automatic runTicks(input int n);
    repeat (n) begin
      @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      if (min_pulse) min_seen++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] y, input logic [7:0] m,
                               input logic [7:0] d, input logic [7:0] h,
                               input logic [7:0] mi, input logic [2:0] w,
                               input logic leap);
    @(negedge clk);
    sync_year = y;
    sync_month = m;
    sync_day = d;
    sync_hour = h;
    sync_minute = mi;
    sync_dow = w;
    leap_announce = leap;
    sync = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    clk_en = 1'b0;
    leap_announce = 1'b0;
    min_mark = min_seen;
  endtask

  initial begin
    $display("[TB] rtc_calendar directed test start");
    repeat (3) @(negedge clk);
    checkTime("reset", 48'h000101000000, 3'd1);
    checkOutput("reset flags", {60'h0, sec_pulse, min_pulse, synced, sync_err}, 64'h0);
    rst_n = 1'b1;

    runTicks(TPS - 1);
    checkOutput("first advance early", {56'h0, second}, 64'h00);
    runTicks(1);
    checkOutput("first advance sec", {56'h0, second}, 64'h01);
    checkOutput("first advance pulse", {63'h0, sec_pulse}, 64'h1);

    // Leap-year February end plus day/dow rollover
    applyStimulus(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 3'd3, 1'b0);
    checkTime("sync load", 48'h240228235900, 3'd3);
    checkOutput("sync load flags", {60'h0, sec_pulse, min_pulse, synced, sync_err}, 64'h2);
    runTicks(60 * TPS);
    checkTime("leap feb", 48'h240229000000, 3'd4);
    checkOutput("leap feb min pulses", 64'(min_seen - min_mark), 64'd1);
    checkOutput("leap feb synced", {63'h0, synced}, 64'h1);

    applyStimulus(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 3'd2, 1'b0);
    runTicks(60 * TPS);
    checkTime("common feb", 48'h230301000000, 3'd3);

    applyStimulus(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 3'd5, 1'b0);
    runTicks(60 * TPS);
    checkTime("century", 48'h000101000000, 3'd6);

    // Rejected syncs leave the time untouched and strobe sync_err once
    applyStimulus(8'h24, 8'h04, 8'h31, 8'h12, 8'h30, 3'd2, 1'b0);
    checkTime("bad day", 48'h000101000000, 3'd6);
    checkOutput("bad day err", {63'h0, sync_err}, 64'h1);
    checkOutput("bad day synced", {63'h0, synced}, 64'h1);
    @(negedge clk);
    checkOutput("bad day err drop", {63'h0, sync_err}, 64'h0);
    applyStimulus(8'h24, 8'h04, 8'h30, 8'h12, 8'h5A, 3'd2, 1'b0);
    checkTime("bad minute", 48'h000101000000, 3'd6);
    checkOutput("bad minute err", {63'h0, sync_err}, 64'h1);

    @(negedge clk);
    sync_year = 8'h24;
    sync_month = 8'h05;
    sync_day = 8'h05;
    sync_hour = 8'h05;
    sync_minute = 8'h05;
    sync_dow = 3'd1;
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    checkTime("clk_en low", 48'h000101000000, 3'd6);
    checkOutput("clk_en low err", {63'h0, sync_err}, 64'h0);

    // Tick counter now sits at its last value: the sync must win
    applyStimulus(8'h24, 8'h06, 8'h15, 8'h10, 8'h59, 3'd6, 1'b1);
    checkTime("sync vs tick", 48'h240615105900, 3'd6);
    checkOutput("sync vs tick pulse", {63'h0, sec_pulse}, 64'h0);
    runTicks(59 * TPS);
    checkOutput("leap sec 59", {48'h0, minute, second}, 64'h5959);
    runTicks(TPS);
    checkOutput("leap sec 60", {48'h0, minute, second}, 64'h5960);
    checkOutput("leap sec no min", 64'(min_seen - min_mark), 64'd0);
    runTicks(TPS);
    checkTime("leap sec wrap", 48'h240615110000, 3'd6);
    runTicks(59 * TPS);
    checkOutput("after leap 59", {48'h0, minute, second}, 64'h0059);
    runTicks(TPS);
    checkOutput("after leap wrap", {40'h0, hour, minute, second}, 64'h110100);

    // Holdover: synced drops on the second minute wrap after a sync
    applyStimulus(8'h24, 8'h06, 8'h15, 8'h12, 8'h00, 3'd6, 1'b0);
    checkOutput("holdover sync", {63'h0, synced}, 64'h1);
    runTicks(60 * TPS);
    checkOutput("holdover 1 min", {63'h0, synced}, 64'h1);
    runTicks(60 * TPS);
    checkOutput("holdover 2 min", {63'h0, synced}, 64'h0);
    checkTime("holdover running", 48'h240615120200, 3'd6);
    applyStimulus(8'h24, 8'h06, 8'h15, 8'h13, 8'h00, 3'd6, 1'b0);
    checkOutput("holdover resync", {63'h0, synced}, 64'h1);

    // Asynchronous reset mid-count with a sync pending
    runTicks(6);
    @(negedge clk);
    sync_hour = 8'h08;
    sync = 1'b1;
    clk_en = 1'b1;
    rst_n = 1'b0;
    #1;
    checkTime("async reset", 48'h000101000000, 3'd1);
    checkOutput("async reset flags", {60'h0, sec_pulse, min_pulse, synced, sync_err}, 64'h0);
    @(negedge clk);
    checkTime("reset holds", 48'h000101000000, 3'd1);
    sync = 1'b0;
    clk_en = 1'b0;
    rst_n = 1'b1;
    runTicks(TPS - 1);
    checkOutput("post reset early", {56'h0, second}, 64'h00);
    runTicks(1);
    checkOutput("post reset advance", {56'h0, second}, 64'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
